// File: rtl/fog_cfg_scheduler_pkg.sv
// fog_cfg_pkg: shared definitions for the FOG configuration scheduler.
//   - register address map (same for shadow and active banks)
//   - scheduler FSM state type
//   - cfg_regs_t: the eleven 32-bit configuration words as one packed bundle
//   - cfg_reset_val(): reset image of a bank
package fog_cfg_pkg;

  localparam logic [3:0] ADDR_FREQ_CNT     = 4'd0;
  localparam logic [3:0] ADDR_AMP_H        = 4'd1;
  localparam logic [3:0] ADDR_AMP_L        = 4'd2;
  localparam logic [3:0] ADDR_POLARITY     = 4'd3;
  localparam logic [3:0] ADDR_WAIT_CNT     = 4'd4;
  localparam logic [3:0] ADDR_ERR_OFFSET   = 4'd5;
  localparam logic [3:0] ADDR_AVG_SEL      = 4'd6;
  localparam logic [3:0] ADDR_CONST_STEP   = 4'd7;
  localparam logic [3:0] ADDR_FB_ON        = 4'd8;
  localparam logic [3:0] ADDR_GAINSEL_STEP = 4'd9;
  localparam logic [3:0] ADDR_GAINSEL_RAMP = 4'd10;
  localparam int         NUM_CFG_REGS      = 11;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_RUN     = 2'd1,
    ST_PENDING = 2'd2
  } cfg_state_t;

  typedef struct packed {
    logic [31:0] gainsel_ramp;
    logic [31:0] gainsel_step;
    logic [31:0] fb_on;
    logic [31:0] const_step;
    logic [31:0] avg_sel;
    logic [31:0] err_offset;
    logic [31:0] wait_cnt;
    logic [31:0] polarity;
    logic [31:0] amp_l;
    logic [31:0] amp_h;
    logic [31:0] freq_cnt;
  } cfg_regs_t;

  function automatic cfg_regs_t cfg_reset_val(input logic [31:0] freq_cnt,
                                              input logic [31:0] wait_cnt);
    cfg_regs_t r;
    r          = '0;
    r.freq_cnt = freq_cnt;
    r.wait_cnt = wait_cnt;
    return r;
  endfunction

endpackage

// File: rtl/fog_cfg_scheduler_if.sv
// fog_cfg_scheduler_if: CPU-side configuration bus of the scheduler.
//   i_wr_en/i_wr_addr/i_wr_data : shadow register write
//   i_commit                    : request atomic apply of the shadow bank
//   o_wr_err                    : 1-cycle pulse, write rejected
//   o_busy                      : commit pending
//   o_commit_done               : 1-cycle pulse, active bank updated
interface fog_cfg_scheduler_if;
  logic        i_wr_en;
  logic [3:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_commit;
  logic        o_wr_err;
  logic        o_busy;
  logic        o_commit_done;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_commit,
    input  o_wr_err, o_busy, o_commit_done
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_commit,
    output o_wr_err, o_busy, o_commit_done
  );
endinterface

// File: rtl/fog_cfg_regbank.sv
// fog_cfg_regbank: shadow register bank with address decode.
//   i_wr_en/i_wr_addr/i_wr_data : CPU write
//   i_lock      : commit pending; writes are rejected to keep the snapshot intact
//   o_shadow    : full shadow bank
//   o_wr_err    : 1-cycle pulse for a locked or out-of-range write
module fog_cfg_regbank
  import fog_cfg_pkg::*;
#(
  parameter logic [31:0] DEF_FREQ_CNT = 32'd100,
  parameter logic [31:0] DEF_WAIT_CNT = 32'd10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_lock,
  output cfg_regs_t   o_shadow,
  output logic        o_wr_err
);

  cfg_regs_t shadow_q, shadow_d;
  logic      wr_err_q, wr_err_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    shadow_d = shadow_q;
    wr_err_d = 1'b0;
    if (i_wr_en) begin
      if (i_lock) begin
        wr_err_d = 1'b1;
      end else begin
        unique case (i_wr_addr)
          ADDR_FREQ_CNT:     shadow_d.freq_cnt     = i_wr_data;
          ADDR_AMP_H:        shadow_d.amp_h        = i_wr_data;
          ADDR_AMP_L:        shadow_d.amp_l        = i_wr_data;
          ADDR_POLARITY:     shadow_d.polarity     = i_wr_data;
          ADDR_WAIT_CNT:     shadow_d.wait_cnt     = i_wr_data;
          ADDR_ERR_OFFSET:   shadow_d.err_offset   = i_wr_data;
          ADDR_AVG_SEL:      shadow_d.avg_sel      = i_wr_data;
          ADDR_CONST_STEP:   shadow_d.const_step   = i_wr_data;
          ADDR_FB_ON:        shadow_d.fb_on        = i_wr_data;
          ADDR_GAINSEL_STEP: shadow_d.gainsel_step = i_wr_data;
          ADDR_GAINSEL_RAMP: shadow_d.gainsel_ramp = i_wr_data;
          default:           wr_err_d              = 1'b1;
        endcase
      end
    end
  end

  // NOTE: the bank is a handful of flops, not a RAM, so it is reset to known
  // defaults; sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q <= cfg_reset_val(DEF_FREQ_CNT, DEF_WAIT_CNT);
      wr_err_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign o_shadow = shadow_q;
  assign o_wr_err = wr_err_q;

endmodule

// File: rtl/fog_cfg_scheduler.sv
// fog_cfg_scheduler: configuration controller for the FOG closed-loop datapath.
//   CPU writes go to a shadow bank; a commit copies the whole bank to the active
//   bank on the next modulation trigger (or after TIMEOUT_CYC cycles), so one
//   modulation half-cycle never sees mixed settings. After reset, feedback is
//   held off for SETTLE_TRIGS triggers.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   cpu            : write/commit bus (fog_cfg_scheduler_if.slave)
//   i_mod_trig     : modulation switching trigger, 1-cycle pulse
//   o_*            : active configuration, o_timeout (sticky), o_settled
module fog_cfg_scheduler
  import fog_cfg_pkg::*;
#(
  parameter int unsigned SETTLE_TRIGS = 16,
  parameter int unsigned TIMEOUT_CYC  = 4096,
  parameter logic [31:0] DEF_FREQ_CNT = 32'd100,
  parameter logic [31:0] DEF_WAIT_CNT = 32'd10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  fog_cfg_scheduler_if.slave  cpu,
  input  logic                i_mod_trig,
  output logic [31:0]         o_freq_cnt,
  output logic [31:0]         o_amp_H,
  output logic [31:0]         o_amp_L,
  output logic [31:0]         o_wait_cnt,
  output logic [31:0]         o_err_offset,
  output logic [31:0]         o_avg_sel,
  output logic [31:0]         o_const_step,
  output logic [31:0]         o_gainSel_step,
  output logic [31:0]         o_gainSel_ramp,
  output logic                o_polarity,
  output logic [31:0]         o_fb_ON,
  output logic                o_timeout,
  output logic                o_settled
);

  localparam int SCW = (SETTLE_TRIGS > 0) ? $clog2(SETTLE_TRIGS + 1) : 1;
  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE_TRIGS);
  localparam logic [TCW-1:0] TMO_MAX    = TCW'(TIMEOUT_CYC - 1);
  localparam cfg_state_t     RST_STATE  = (SETTLE_TRIGS == 0) ? ST_RUN : ST_SETTLE;

  cfg_state_t     state_q, state_d;
  cfg_regs_t      active_q, active_d;
  cfg_regs_t      shadow;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           timeout_q, timeout_d;
  logic           settled_q, settled_d;
  logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic           apply, commit_ok;

  fog_cfg_regbank #(
    .DEF_FREQ_CNT(DEF_FREQ_CNT),
    .DEF_WAIT_CNT(DEF_WAIT_CNT)
  ) u_regbank (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr_en  (cpu.i_wr_en),
    .i_wr_addr(cpu.i_wr_addr),
    .i_wr_data(cpu.i_wr_data),
    .i_lock   (busy_q),
    .o_shadow (shadow),
    .o_wr_err (cpu.o_wr_err)
  );

  // busy_q is the pending flag in every state: a commit taken during SETTLE
  // follows the same apply rules without leaving SETTLE.
  assign apply     = busy_q && (i_mod_trig || (tmo_cnt_q == TMO_MAX));
  assign commit_ok = cpu.i_commit && !busy_q;

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    settled_d    = settled_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;

    if (apply) begin
      active_d  = shadow;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      tmo_cnt_d = '0;
      timeout_d = !i_mod_trig;  // a trigger-based apply clears the sticky flag
    end else if (busy_q) begin
      tmo_cnt_d = tmo_cnt_q + TCW'(1);
    end

    // A commit seen in the same cycle as a trigger only arms; the apply waits
    // for the next trigger.
    if (commit_ok) begin
      busy_d    = 1'b1;
      tmo_cnt_d = '0;
    end

    unique case (state_q)
      ST_SETTLE: begin
        if (i_mod_trig && (settle_cnt_q != SETTLE_MAX)) begin
          settle_cnt_d = settle_cnt_q + SCW'(1);
          if (settle_cnt_d == SETTLE_MAX) begin
            settled_d = 1'b1;
            state_d   = busy_d ? ST_PENDING : ST_RUN;
          end
        end
      end
      ST_RUN:     if (commit_ok) state_d = ST_PENDING;
      ST_PENDING: if (apply)     state_d = ST_RUN;
      default:    state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= RST_STATE;
      active_q     <= cfg_reset_val(DEF_FREQ_CNT, DEF_WAIT_CNT);
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      settled_q    <= 1'(SETTLE_TRIGS == 0);
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      settled_q    <= settled_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign cpu.o_busy        = busy_q;
  assign cpu.o_commit_done = done_q;

  assign o_freq_cnt     = active_q.freq_cnt;
  assign o_amp_H        = active_q.amp_h;
  assign o_amp_L        = active_q.amp_l;
  assign o_wait_cnt     = active_q.wait_cnt;
  assign o_err_offset   = active_q.err_offset;
  assign o_avg_sel      = active_q.avg_sel;
  assign o_const_step   = active_q.const_step;
  assign o_gainSel_step = active_q.gainsel_step;
  assign o_gainSel_ramp = active_q.gainsel_ramp;
  assign o_polarity     = active_q.polarity[0];
  assign o_fb_ON        = (state_q == ST_SETTLE) ? 32'd0 : active_q.fb_on;
  assign o_timeout      = timeout_q;
  assign o_settled      = settled_q;

endmodule

// File: tb/tb_fog_cfg_scheduler.sv
// Self-checking bench for fog_cfg_scheduler (SETTLE_TRIGS=4, TIMEOUT_CYC=64).
// A small behavioural model tracks the shadow bank and pending state; every
// accepted commit pushes its snapshot to a scoreboard that is popped when the
// DUT reports o_commit_done.
module tb_fog_cfg_scheduler;
  import fog_cfg_pkg::*;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mod_trig = 1'b0;
  logic [31:0] freq_cnt, amp_h, amp_l, wait_cnt, err_offset, avg_sel;
  logic [31:0] const_step, gain_step, gain_ramp, fb_on;
  logic        polarity, timeout, settled;

  fog_cfg_scheduler_if cpu_if ();

  fog_cfg_scheduler #(
    .SETTLE_TRIGS(SETTLE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .cpu           (cpu_if),
    .i_mod_trig    (mod_trig),
    .o_freq_cnt    (freq_cnt),
    .o_amp_H       (amp_h),
    .o_amp_L       (amp_l),
    .o_wait_cnt    (wait_cnt),
    .o_err_offset  (err_offset),
    .o_avg_sel     (avg_sel),
    .o_const_step  (const_step),
    .o_gainSel_step(gain_step),
    .o_gainSel_ramp(gain_ramp),
    .o_polarity    (polarity),
    .o_fb_ON       (fb_on),
    .o_timeout     (timeout),
    .o_settled     (settled)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_pass   = 0;
  int        n_done   = 0;
  int        n_apply  = 0;
  cfg_regs_t sh_model;
  cfg_regs_t sb[$];
  bit        model_busy;
  int        model_tmo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic cfg_regs_t model_reset();
    cfg_regs_t r;
    r          = '0;
    r.freq_cnt = 32'd100;
    r.wait_cnt = 32'd10;
    return r;
  endfunction

  function automatic cfg_regs_t model_write(input cfg_regs_t r, input logic [3:0] a,
                                            input logic [31:0] d);
    case (a)
      4'd0:  r.freq_cnt     = d;
      4'd1:  r.amp_h        = d;
      4'd2:  r.amp_l        = d;
      4'd3:  r.polarity     = d;
      4'd4:  r.wait_cnt     = d;
      4'd5:  r.err_offset   = d;
      4'd6:  r.avg_sel      = d;
      4'd7:  r.const_step   = d;
      4'd8:  r.fb_on        = d;
      4'd9:  r.gainsel_step = d;
      4'd10: r.gainsel_ramp = d;
      default: ;
    endcase
    return r;
  endfunction

  // One clock: update the model from the driven inputs, clock, check the
  // handshake outputs, then drop all pulse inputs.
  task automatic step();
    bit do_apply, exp_err;
    do_apply = 1'b0;
    exp_err  = 1'b0;
    if (rst_n) begin
      do_apply = model_busy && (mod_trig || model_tmo == int'(TMO) - 1);
      exp_err  = cpu_if.i_wr_en && (model_busy || cpu_if.i_wr_addr > 4'd10);
      if (cpu_if.i_wr_en && !exp_err)
        sh_model = model_write(sh_model, cpu_if.i_wr_addr, cpu_if.i_wr_data);
      if (cpu_if.i_commit && !model_busy) begin
        sb.push_back(sh_model);
        model_busy = 1'b1;
        model_tmo  = 0;
      end else if (do_apply) begin
        model_busy = 1'b0;
        n_apply++;
      end else if (model_busy) begin
        model_tmo++;
      end
    end
    @(posedge clk);
    #1;
    check("busy", 32'(cpu_if.o_busy), 32'(model_busy));
    check("wr_err", 32'(cpu_if.o_wr_err), 32'(exp_err));
    check("commit_done", 32'(cpu_if.o_commit_done), 32'(do_apply));
    cpu_if.i_wr_en  = 1'b0;
    cpu_if.i_commit = 1'b0;
    mod_trig        = 1'b0;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [31:0] d);
    cpu_if.i_wr_en   = 1'b1;
    cpu_if.i_wr_addr = a;
    cpu_if.i_wr_data = d;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    set_wr(a, d);
    step();
  endtask

  task automatic commit();
    cpu_if.i_commit = 1'b1;
    step();
  endtask

  task automatic trig();
    mod_trig = 1'b1;
    step();
  endtask

  task automatic model_clear();
    sh_model   = model_reset();
    model_busy = 1'b0;
    model_tmo  = 0;
    sb.delete();
  endtask

  // Scoreboard: compare every applied snapshot, sampled away from the edge.
  always @(posedge clk) begin
    #2;
    if (rst_n && cpu_if.o_commit_done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check("sb_unexpected_apply", 32'd1, 32'd0);
      end else begin
        cfg_regs_t e;
        e = sb.pop_front();
        check("sb_freq_cnt", freq_cnt, e.freq_cnt);
        check("sb_amp_H", amp_h, e.amp_h);
        check("sb_amp_L", amp_l, e.amp_l);
        check("sb_wait_cnt", wait_cnt, e.wait_cnt);
        check("sb_err_offset", err_offset, e.err_offset);
        check("sb_avg_sel", avg_sel, e.avg_sel);
        check("sb_const_step", const_step, e.const_step);
        check("sb_gainSel_step", gain_step, e.gainsel_step);
        check("sb_gainSel_ramp", gain_ramp, e.gainsel_ramp);
        check("sb_polarity", 32'(polarity), 32'(e.polarity[0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    cpu_if.i_wr_en   = 1'b0;
    cpu_if.i_wr_addr = 4'd0;
    cpu_if.i_wr_data = 32'd0;
    cpu_if.i_commit  = 1'b0;
    model_clear();

    // Reset values
    rst_n = 1'b0;
    step();
    step();
    check("rst_freq_cnt", freq_cnt, 32'd100);
    check("rst_wait_cnt", wait_cnt, 32'd10);
    check("rst_amp_H", amp_h, 32'd0);
    check("rst_fb_ON", fb_on, 32'd0);
    check("rst_settled", 32'(settled), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step();

    // Settle: fb_ON=1 committed during settle stays gated until the 4th trigger
    wr(4'd8, 32'd1);
    commit();
    trig();
    check("settle1_fb_ON", fb_on, 32'd0);
    check("settle1_settled", 32'(settled), 32'd0);
    step();
    trig();
    trig();
    check("settle3_fb_ON", fb_on, 32'd0);
    check("settle3_settled", 32'(settled), 32'd0);
    step();
    trig();
    check("settle4_settled", 32'(settled), 32'd1);
    check("settle4_fb_ON", fb_on, 32'd1);

    // Atomic apply after 20 cycles; write rejected and re-commit ignored while busy
    wr(4'd1, 32'd500);
    wr(4'd2, 32'hFFFF_FE0C);
    commit();
    for (int i = 1; i < 20; i++) begin
      if (i == 5) cpu_if.i_commit = 1'b1;
      if (i == 10) set_wr(4'd1, 32'd777);
      step();
      check("busy_amp_H_held", amp_h, 32'd0);
    end
    trig();
    check("apply_amp_H", amp_h, 32'd500);
    check("apply_amp_L", amp_l, 32'hFFFF_FE0C);
    step();
    wr(4'd12, 32'd5);
    commit();
    trig();
    check("rejected_write_amp_H", amp_h, 32'd500);

    // Timeout apply
    wr(4'd7, 32'h1234);
    commit();
    k = 0;
    while (cpu_if.o_busy === 1'b1 && k < 200) begin
      step();
      k++;
    end
    check("tmo_busy_cycles", k, 64);
    check("tmo_flag_set", 32'(timeout), 32'd1);
    check("tmo_const_step", const_step, 32'h1234);
    commit();
    step();
    step();
    check("tmo_flag_sticky", 32'(timeout), 32'd1);
    trig();
    check("tmo_flag_cleared", 32'(timeout), 32'd0);

    // Write + commit + trigger in one cycle: no apply on that trigger
    set_wr(4'd0, 32'd250);
    cpu_if.i_commit = 1'b1;
    mod_trig = 1'b1;
    step();
    check("same_cycle_freq_held", freq_cnt, 32'd100);
    step();
    step();
    check("same_cycle_freq_held2", freq_cnt, 32'd100);
    trig();
    check("same_cycle_freq_apply", freq_cnt, 32'd250);

    // Reset while a commit is pending
    wr(4'd0, 32'd77);
    commit();
    step();
    step();
    rst_n = 1'b0;
    model_clear();
    #1;
    check("midrst_freq_cnt", freq_cnt, 32'd100);
    check("midrst_amp_H", amp_h, 32'd0);
    check("midrst_busy", 32'(cpu_if.o_busy), 32'd0);
    check("midrst_settled", 32'(settled), 32'd0);
    check("midrst_fb_ON", fb_on, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    trig();
    check("post_rst_settled", 32'(settled), 32'd0);
    check("post_rst_freq_cnt", freq_cnt, 32'd100);

    check("done_count", n_done, n_apply);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fog_cfg_scheduler.md
Name: fog_cfg_scheduler

Overview:
Configuration controller for the FOG closed-loop datapath (modulation gen, err signal gen, feedback step gen, phase ramp gen).
- CPU writes land in a shadow register bank.
- On a commit request, all shadow values are applied to the datapath atomically on the next modulation switching trigger, so a single modulation half-cycle never sees mixed settings.
- A post-reset settle sequence holds feedback off for a programmable number of modulation triggers before releasing the loop.

Parameters:
SETTLE_TRIGS, 16, number of i_mod_trig pulses after reset during which o_fb_ON is forced 0 (0 = skip settle)
TIMEOUT_CYC, 4096, max i_clk cycles a pending commit waits for i_mod_trig before forced apply
DEF_FREQ_CNT, 32'd100, reset value of active/shadow freq_cnt
DEF_WAIT_CNT, 32'd10, reset value of active/shadow wait_cnt

Ports:
i_clk  in  1  system clock (DAC clock domain)
i_rst_n  in  1  asynchronous active-low reset
i_wr_en  in  1  shadow write strobe
i_wr_addr  in  4  shadow register index
i_wr_data  in  32  shadow write data
i_commit  in  1  pulse: request atomic apply of shadow bank
i_mod_trig  in  1  modulation switching trigger (stepTrig), 1-cycle pulse
o_freq_cnt, o_amp_H, o_amp_L, o_wait_cnt, o_err_offset, o_avg_sel, o_const_step, o_gainSel_step, o_gainSel_ramp  out  32 each  active config
o_polarity  out  1  active polarity (bit0 of reg 3)
o_fb_ON  out  32  active feedback enable, gated by settle state
o_busy  out  1  commit pending
o_commit_done  out  1  1-cycle pulse when active regs updated
o_timeout  out  1  sticky: a commit was force-applied by timeout; cleared by next normal apply
o_wr_err  out  1  1-cycle pulse: write rejected
o_settled  out  1  settle sequence complete

Behaviour:
- Clock/reset: one clock i_clk; reset i_rst_n asynchronous, active-low.
- Address map, same for shadow and active:
  - 0 freq_cnt, 1 amp_H, 2 amp_L, 3 polarity (bit0, upper bits stored, ignored), 4 wait_cnt, 5 err_offset
  - 6 avg_sel, 7 const_step, 8 fb_ON, 9 gainSel_step, 10 gainSel_ramp
  - 11-15: write ignored, o_wr_err pulses.
- Reset values:
  - All shadow and active regs 0, except freq_cnt=DEF_FREQ_CNT and wait_cnt=DEF_WAIT_CNT.
  - o_busy=0, o_commit_done=0, o_timeout=0, o_wr_err=0.
  - o_settled=(SETTLE_TRIGS==0).
  - State=SETTLE, or RUN if SETTLE_TRIGS==0.
- FSM states: SETTLE, RUN, PENDING.
  - SETTLE: counts i_mod_trig pulses. When the count reaches SETTLE_TRIGS, go to RUN the next cycle and set o_settled=1. Writes and commits are accepted here; a commit updates active regs on the next i_mod_trig, with the same rules as PENDING, without leaving SETTLE. o_fb_ON=0 throughout SETTLE.
  - RUN: o_fb_ON = active fb_ON. i_commit=1 -> PENDING, o_busy=1, timeout counter cleared.
  - PENDING: exit on i_mod_trig=1, or timeout counter == TIMEOUT_CYC-1.
    - Next cycle: all active regs <= shadow, o_commit_done=1, o_busy=0, state RUN.
    - Timeout exit also sets o_timeout=1.
- Latency: i_mod_trig sampled at edge t -> active outputs and o_commit_done change at edge t+1. Apply latency is exactly 1 cycle.
- Write rules:
  - Writes in SETTLE/RUN update the addressed shadow reg at the next edge.
  - Writes while o_busy=1 are rejected (shadow unchanged, o_wr_err pulse) to preserve the snapshot.
  - i_wr_en and i_commit in the same RUN cycle: the write is included in the snapshot.
  - i_commit while o_busy=1 is ignored (no error).
- i_commit and i_mod_trig in the same RUN cycle: enter PENDING only. Apply on the next trigger, never the same cycle.
- Active regs change only on apply. Shadow contents are never cleared by apply.
- Reset mid-PENDING: pending commit is discarded, all regs return to reset values, FSM re-enters SETTLE.
- Counters:
  - Settle counter: width $clog2(SETTLE_TRIGS+1), saturating.
  - Timeout counter: $clog2(TIMEOUT_CYC), no wrap.

Decomposition:
- Package fog_cfg_pkg:
  - address localparams (ADDR_FREQ_CNT..ADDR_GAINSEL_RAMP, NUM_CFG_REGS=11)
  - state enum typedef cfg_state_t
  - a cfg_regs_t packed struct of the eleven 32-bit fields, used for both shadow and active banks
- One natural sub-module: fog_cfg_regbank, the shadow bank with address decode and write-reject logic. The FSM, timeout and settle logic stay in the top.

Test Plan:
- Reset, SETTLE_TRIGS=4, active fb_ON=1 committed during settle -> o_fb_ON=0 until the 4th i_mod_trig; o_settled=1 and o_fb_ON=1 one cycle after that trig.
- Write amp_H=500, amp_L=-500, commit, i_mod_trig 20 cycles later -> o_busy=1 for 20 cycles; both outputs change together 1 cycle after trig; o_commit_done pulses once.
- Write addr 1 while busy -> o_wr_err pulse; after apply, o_amp_H keeps the pre-busy shadow value.
- Commit with no i_mod_trig, TIMEOUT_CYC=64 -> apply at cycle 64 after commit; o_timeout=1; next trig-based commit clears it.
- i_wr_en (addr 0, data 250) with i_commit and i_mod_trig in the same cycle -> no apply on that trig; o_freq_cnt=250 one cycle after the next trig.
- Assert i_rst_n low mid-PENDING -> outputs return to defaults immediately (o_freq_cnt=100), o_busy=0, FSM in SETTLE.
